// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store sequencer: access sizes, error codes,
// FSM states and the alignment rule.
package lsu_pkg;

   localparam logic [1:0] SIZE_B = 2'b00;
   localparam logic [1:0] SIZE_H = 2'b01;
   localparam logic [1:0] SIZE_W = 2'b10;
   localparam logic [1:0] SIZE_X = 2'b11;

   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_MISALIGN = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
   localparam logic [1:0] ERR_SIZE     = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REQ  = 2'b01,
      ST_WAIT = 2'b10,
      ST_DONE = 2'b11
   } state_t;

   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] offset);
      logic bad;
      case (size)
         SIZE_H:  bad = offset[0];
         SIZE_W:  bad = (offset != 2'b00);
         default: bad = 1'b0;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering: byte enables and replicated store data, plus load-data
// extraction with sign/zero extension.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [1:0]  st_size,
   input  logic [1:0]  st_offset,
   input  logic [31:0] st_data,
   input  logic [1:0]  ld_size,
   input  logic [1:0]  ld_offset,
   input  logic        ld_unsigned,
   input  logic [31:0] ld_data,
   output logic [3:0]  be,
   output logic [31:0] wdata_lanes,
   output logic [31:0] rdata_ext
);

   logic [31:0] shifted_s;

   // Store side: byte enables and lane-replicated write data.
   always_comb begin
      be          = 4'b0000;
      wdata_lanes = 32'h0000_0000;
      case (st_size)
         SIZE_B: begin
            be          = 4'b0001 << st_offset;
            wdata_lanes = {4{st_data[7:0]}};
         end
         SIZE_H: begin
            be          = 4'b0011 << {st_offset[1], 1'b0};
            wdata_lanes = {2{st_data[15:0]}};
         end
         SIZE_W: begin
            be          = 4'b1111;
            wdata_lanes = st_data;
         end
         default: begin
            be          = 4'b0000;
            wdata_lanes = 32'h0000_0000;
         end
      endcase
   end

   // Load side: bring the addressed bytes to bit 0, then extend.
   always_comb begin
      shifted_s = ld_data >> {ld_offset, 3'b000};
      rdata_ext = shifted_s;
      case (ld_size)
         SIZE_B: rdata_ext = ld_unsigned ? {24'h00_0000, shifted_s[7:0]}
                                         : {{24{shifted_s[7]}}, shifted_s[7:0]};
         SIZE_H: rdata_ext = ld_unsigned ? {16'h0000, shifted_s[15:0]}
                                         : {{16{shifted_s[15]}}, shifted_s[15:0]};
         default: rdata_ext = shifted_s;
      endcase
   end

endmodule

// File: rtl/lsu.sv
// Load/store sequencer: one access at a time over a req/gnt/rvalid memory
// port, with alignment checking and an access timeout.
module lsu
   import lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [1:0]  size_i,
   input  logic        unsigned_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [31:0] rdata_o,
   output logic        err_o,
   output logic [1:0]  err_code_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i
);

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t      state_r, state_n;
   logic [7:0]  cnt_r, cnt_n;
   logic        we_r, uns_r;
   logic [1:0]  size_r, off_r;
   logic        accept_s;
   logic        done_n, err_n, mem_req_n;
   logic [1:0]  code_n;
   logic [31:0] rdata_n;
   logic [3:0]  be_s;
   logic [31:0] lanes_s, ext_s;

   lsu_align u_align (
      .st_size     (size_i),
      .st_offset   (addr_i[1:0]),
      .st_data     (wdata_i),
      .ld_size     (size_r),
      .ld_offset   (off_r),
      .ld_unsigned (uns_r),
      .ld_data     (mem_rdata_i),
      .be          (be_s),
      .wdata_lanes (lanes_s),
      .rdata_ext   (ext_s)
   );

   assign accept_s = (state_r == ST_IDLE) && req_i;

   // Next state and next values of the registered outputs.
   always_comb begin
      state_n   = state_r;
      cnt_n     = cnt_r;
      done_n    = 1'b0;
      err_n     = 1'b0;
      code_n    = ERR_NONE;
      rdata_n   = rdata_o;
      mem_req_n = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (!req_i) begin
               state_n = ST_IDLE;
            end else if (size_i == SIZE_X) begin
               state_n = ST_DONE;
               done_n  = 1'b1;
               err_n   = 1'b1;
               code_n  = ERR_SIZE;
               rdata_n = 32'h0000_0000;
            end else if (misaligned(size_i, addr_i[1:0])) begin
               state_n = ST_DONE;
               done_n  = 1'b1;
               err_n   = 1'b1;
               code_n  = ERR_MISALIGN;
               rdata_n = 32'h0000_0000;
            end else begin
               state_n   = ST_REQ;
               cnt_n     = 8'd0;
               mem_req_n = 1'b1;
            end
         end
         ST_REQ: begin
            cnt_n = cnt_r + 8'd1;
            // A grant in the last allowed cycle is not a completion, so timeout wins.
            if (cnt_r == CNT_LAST) begin
               state_n = ST_DONE;
               done_n  = 1'b1;
               err_n   = 1'b1;
               code_n  = ERR_TIMEOUT;
               rdata_n = 32'h0000_0000;
            end else if (mem_gnt_i) begin
               state_n = ST_WAIT;
            end else begin
               mem_req_n = 1'b1;
            end
         end
         ST_WAIT: begin
            cnt_n = cnt_r + 8'd1;
            if (mem_rvalid_i) begin
               state_n = ST_DONE;
               done_n  = 1'b1;
               if (!we_r) begin
                  rdata_n = ext_s;
               end else begin
                  rdata_n = rdata_o;
               end
            end else if (cnt_r == CNT_LAST) begin
               state_n = ST_DONE;
               done_n  = 1'b1;
               err_n   = 1'b1;
               code_n  = ERR_TIMEOUT;
               rdata_n = 32'h0000_0000;
            end else begin
               state_n = ST_WAIT;
            end
         end
         ST_DONE: begin
            state_n = ST_IDLE;
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

   // State, access context and registered outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r     <= ST_IDLE;
         cnt_r       <= 8'd0;
         we_r        <= 1'b0;
         uns_r       <= 1'b0;
         size_r      <= 2'b00;
         off_r       <= 2'b00;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         rdata_o     <= 32'h0000_0000;
         err_o       <= 1'b0;
         err_code_o  <= ERR_NONE;
         mem_req_o   <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= 32'h0000_0000;
         mem_be_o    <= 4'b0000;
         mem_wdata_o <= 32'h0000_0000;
      end else begin
         state_r    <= state_n;
         cnt_r      <= cnt_n;
         busy_o     <= (state_n != ST_IDLE);
         done_o     <= done_n;
         rdata_o    <= rdata_n;
         err_o      <= err_n;
         err_code_o <= code_n;
         mem_req_o  <= mem_req_n;
         if (accept_s) begin
            we_r        <= we_i;
            uns_r       <= unsigned_i;
            size_r      <= size_i;
            off_r       <= addr_i[1:0];
            mem_we_o    <= we_i;
            mem_addr_o  <= {addr_i[31:2], 2'b00};
            mem_be_o    <= be_s;
            mem_wdata_o <= lanes_s;
         end
      end
   end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed scenarios then randomized accesses,
// all judged against a cycle-count/arithmetic model of the access rules.
module tb_lsu;

   localparam int TO = 4;

   logic        clk_i = 1'b0;
   logic        rst_i, req_i, we_i, unsigned_i;
   logic [1:0]  size_i;
   logic [31:0] addr_i, wdata_i;
   logic        busy_o, done_o, err_o, mem_req_o, mem_we_o;
   logic [31:0] rdata_o, mem_addr_o, mem_wdata_o;
   logic [1:0]  err_code_o;
   logic [3:0]  mem_be_o;
   logic        mem_gnt_i, mem_rvalid_i;
   logic [31:0] mem_rdata_i;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] model_rdata = 32'h0;

   always #5 clk_i = ~clk_i;

   lsu #(.TIMEOUT(TO)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .size_i(size_i),
      .unsigned_i(unsigned_i), .addr_i(addr_i), .wdata_i(wdata_i),
      .busy_o(busy_o), .done_o(done_o), .rdata_o(rdata_o), .err_o(err_o),
      .err_code_o(err_code_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
      .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
      .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One access: g = REQ cycles without grant before the grant cycle,
   // r = WAIT cycles without rvalid before the response.
   task automatic run_access(input logic we, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] mem, input int g, input int r);
      int          done_c, req_last;
      logic [1:0]  off, code;
      logic [3:0]  be;
      logic [31:0] lanes, ext, shifted;
      logic        mem_path;
      off = addr[1:0];
      if (size == 2'b11)                                            code = 2'd3;
      else if ((size == 2'b01 && off[0]) || (size == 2'b10 && off != 2'd0)) code = 2'd1;
      else if (g + r + 2 <= TO)                                     code = 2'd0;
      else                                                          code = 2'd2;
      mem_path = (code == 2'd0) || (code == 2'd2);
      if (!mem_path)         begin done_c = 1;         req_last = 0; end
      else if (code == 2'd0) begin done_c = g + r + 3; req_last = g + 1; end
      else                   begin done_c = TO + 1;    req_last = (g + 1 < TO) ? g + 1 : TO; end
      case (size)
         2'b00:   begin be = 4'b0001 << off; lanes = {4{wdata[7:0]}}; end
         2'b01:   begin be = 4'b0011 << off; lanes = {2{wdata[15:0]}}; end
         default: begin be = 4'b1111;        lanes = wdata; end
      endcase
      shifted = mem >> (8 * int'(off));
      case (size)
         2'b00:   ext = uns ? {24'h0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
         2'b01:   ext = uns ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
         default: ext = mem;
      endcase

      @(negedge clk_i);
      req_i = 1'b1; we_i = we; size_i = size; unsigned_i = uns;
      addr_i = addr; wdata_i = wdata; mem_rdata_i = mem;
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
      for (int c = 1; c <= done_c + 1; c++) begin
         @(negedge clk_i);
         check("busy", 32'(busy_o), 32'(c <= done_c));
         check("done", 32'(done_o), 32'(c == done_c));
         check("mem_req", 32'(mem_req_o), 32'(c <= req_last));
         if (c <= req_last) begin
            check("mem_we", 32'(mem_we_o), 32'(we));
            check("mem_addr", mem_addr_o, {addr[31:2], 2'b00});
            check("mem_be", 32'(mem_be_o), 32'(be));
            check("mem_wdata", mem_wdata_o, lanes);
         end
         if (c == done_c) begin
            if (code != 2'd0)  model_rdata = 32'h0;
            else if (!we)      model_rdata = ext;
            check("err", 32'(err_o), 32'(code != 2'd0));
            check("err_code", 32'(err_code_o), 32'(code));
            check("rdata", rdata_o, model_rdata);
         end
         req_i        = (c == done_c);
         mem_gnt_i    = mem_path && (c == g + 1);
         mem_rvalid_i = mem_path && ((c <= g + 1) ? 1'($urandom_range(0, 1)) : (c == g + r + 2));
      end
      req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
   endtask

   initial begin
      logic [1:0]  rs;
      logic [31:0] ra;
      rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; size_i = 2'b00; unsigned_i = 1'b0;
      addr_i = 32'h0; wdata_i = 32'h0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
      mem_rdata_i = 32'h0;
      repeat (3) @(negedge clk_i);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_done", 32'(done_o), 32'd0);
      check("rst_rdata", rdata_o, 32'h0);
      check("rst_err", {29'd0, err_o, err_code_o}, 32'd0);
      check("rst_memctl", {26'd0, mem_req_o, mem_we_o, mem_be_o}, 32'd0);
      check("rst_memaddr", mem_addr_o, 32'h0);
      check("rst_memwdata", mem_wdata_o, 32'h0);
      rst_i = 1'b0;

      run_access(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, 0);
      run_access(1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0, 32'h8012_3456, 0, 0);
      run_access(1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0, 32'h8012_3456, 0, 0);
      run_access(1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h0000_ABCD, 32'h0, 1, 0);
      run_access(1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'h0, 32'h0, 0, 0);
      run_access(1'b0, 2'b11, 1'b0, 32'h0000_0101, 32'h0, 32'h0, 0, 0);
      run_access(1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0, 32'h1111_2222, 10, 0);
      mem_rvalid_i = 1'b1;
      @(negedge clk_i);
      check("late_rvalid_done", 32'(done_o), 32'd0);
      check("late_rvalid_busy", 32'(busy_o), 32'd0);
      mem_rvalid_i = 1'b0;
      run_access(1'b0, 2'b01, 1'b0, 32'h0000_0402, 32'h0, 32'h9ABC_0000, 0, 2);
      run_access(1'b0, 2'b01, 1'b0, 32'h0000_0402, 32'h0, 32'h9ABC_0000, 3, 0);

      // Reset while the access waits for its response.
      @(negedge clk_i);
      req_i = 1'b1; we_i = 1'b0; size_i = 2'b10; addr_i = 32'h0000_0040;
      @(negedge clk_i);
      check("rstw_req", 32'(mem_req_o), 32'd1);
      req_i = 1'b0; mem_gnt_i = 1'b1;
      @(negedge clk_i);
      check("rstw_wait_req", 32'(mem_req_o), 32'd0);
      check("rstw_wait_busy", 32'(busy_o), 32'd1);
      mem_gnt_i = 1'b0; rst_i = 1'b1;
      @(negedge clk_i);
      check("rstw_busy", 32'(busy_o), 32'd0);
      check("rstw_memreq", 32'(mem_req_o), 32'd0);
      check("rstw_memaddr", mem_addr_o, 32'h0);
      model_rdata = 32'h0;
      rst_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1234_5678;
      @(negedge clk_i);
      check("rstw_no_done", 32'(done_o), 32'd0);
      check("rstw_idle", 32'(busy_o), 32'd0);
      mem_rvalid_i = 1'b0;
      run_access(1'b0, 2'b10, 1'b0, 32'h0000_0044, 32'h0, 32'h0BAD_F00D, 0, 1);

      for (int i = 0; i < 150; i++) begin
         rs = ($urandom_range(0, 9) < 9) ? 2'($urandom_range(0, 2)) : 2'b11;
         ra = $urandom;
         if ($urandom_range(0, 3) != 0) begin
            if (rs == 2'b10)      ra[1:0] = 2'b00;
            else if (rs == 2'b01) ra[0]   = 1'b0;
            else                  ra[1:0] = ra[1:0];
         end
         run_access(1'($urandom_range(0, 1)), rs, 1'($urandom_range(0, 1)), ra,
                    $urandom, $urandom, $urandom_range(0, 4), $urandom_range(0, 3));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
